// File: rtl/rv_pipe_pkg.sv
// Shared pipeline-control types for the RV32IM core: mul/div FSM states,
// operand-forward select codes and the hazard scoreboard entry.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b11;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  // Youngest producer wins: an EX match shadows an older MEM match.
  function automatic logic [1:0] fwd_sel(input logic       uses,
                                         input logic [4:0] rs,
                                         input sb_entry_t  ex,
                                         input sb_entry_t  mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (uses && rs != 5'd0) begin
      if (ex.valid && ex.rd == rs)
        sel = FWD_EXMEM;
      else if (mem.valid && mem.rd == rs)
        sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow scoreboard of in-flight destination registers; produces the
// load-use hazard flag and the registered EX forwarding selects.
module hazard_scoreboard
  import rv_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_advance,
  input  logic       pipe_hold,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_is_load,
  output logic       load_use,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  // The WB instruction writes the register file ahead of the ID read, so
  // only EX and MEM producers need tracking for forwarding and stalls.
  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t id_entry;

  assign id_entry = '{valid:   id_valid & id_reg_write & (id_rd != 5'd0),
                      rd:      id_rd,
                      is_load: id_is_load};

  assign load_use = id_valid & ex_q.valid & ex_q.is_load &
                    ((id_uses_rs1 & (id_rs1 == ex_q.rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_q.rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (pipe_hold) begin
      // Mul/div occupies EX: it and its selects stay put, MEM drains.
      mem_q <= '0;
    end else begin
      mem_q <= ex_q;
      if (id_advance) begin
        ex_q      <= id_entry;
        fwd_a_sel <= id_valid ? fwd_sel(id_uses_rs1, id_rs1, ex_q, mem_q) : FWD_RF;
        fwd_b_sel <= id_valid ? fwd_sel(id_uses_rs2, id_rs2, ex_q, mem_q) : FWD_RF;
      end else begin
        ex_q      <= '0;
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-side sequencing controller: load-use stalls, branch flushes and the
// iterative mul/div start/stall FSM, with forwarding from the scoreboard.
module hazard_stall_controller
  import rv_pipe_pkg::*;
#(
  parameter int MULDIV_MIN_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ID_VALID,
  input  logic [4:0] ID_RS1,
  input  logic [4:0] ID_RS2,
  input  logic       ID_USES_RS1,
  input  logic       ID_USES_RS2,
  input  logic [4:0] ID_RD,
  input  logic       ID_REG_WRITE,
  input  logic       ID_IS_LOAD,
  input  logic       ID_IS_MULDIV,
  input  logic       BRANCH_TAKEN,
  input  logic       MULDIV_DONE,
  output logic       PC_STALL,
  output logic       IFID_STALL,
  output logic       IFID_FLUSH,
  output logic       IDEX_BUBBLE,
  output logic       IDEX_HOLD,
  output logic       MULDIV_START,
  output logic [1:0] FWD_A_SEL,
  output logic [1:0] FWD_B_SEL
);

  // The counter holds completed BUSY cycles, so DONE is honoured once
  // completed + current >= MULDIV_MIN_CYCLES.
  localparam logic [15:0] MIN_M1 =
    16'((MULDIV_MIN_CYCLES > 0) ? MULDIV_MIN_CYCLES - 1 : 0);

  md_state_t   state_q;
  logic [15:0] cnt_q;
  logic        load_use;
  logic        idle;
  logic        flush;
  logic        stall_lu;
  logic        id_advance;
  logic        start_md;
  logic        done_ok;

  assign idle       = (state_q == ST_IDLE);
  assign flush      = idle & BRANCH_TAKEN;
  assign stall_lu   = idle & load_use & ~flush;
  assign id_advance = idle & ~flush & ~load_use;
  assign start_md   = id_advance & ID_VALID & ID_IS_MULDIV;
  assign done_ok    = MULDIV_DONE & (cnt_q >= MIN_M1);

  assign PC_STALL    = RESET_N & (stall_lu | ~idle);
  assign IFID_STALL  = RESET_N & (stall_lu | ~idle);
  assign IFID_FLUSH  = RESET_N & flush;
  assign IDEX_BUBBLE = RESET_N & (flush | stall_lu);
  assign IDEX_HOLD   = RESET_N & ~idle;

  hazard_scoreboard u_scoreboard (
    .clk          (CLK),
    .rst_n        (RESET_N),
    .id_advance   (id_advance),
    .pipe_hold    (~idle),
    .id_valid     (ID_VALID),
    .id_rs1       (ID_RS1),
    .id_rs2       (ID_RS2),
    .id_uses_rs1  (ID_USES_RS1),
    .id_uses_rs2  (ID_USES_RS2),
    .id_rd        (ID_RD),
    .id_reg_write (ID_REG_WRITE),
    .id_is_load   (ID_IS_LOAD),
    .load_use     (load_use),
    .fwd_a_sel    (FWD_A_SEL),
    .fwd_b_sel    (FWD_B_SEL)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      MULDIV_START <= 1'b0;
    end else begin
      MULDIV_START <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_md) begin
            state_q      <= ST_BUSY;
            cnt_q        <= '0;
            MULDIV_START <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (done_ok)
            state_q <= ST_DONE;
          if (cnt_q != '1)
            cnt_q <= cnt_q + 16'd1;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
